repeat_edge_pad_stream: RTL and testbench
=========================================

// Module: repeat_edge_pad_stream
// PURPOSE
//  Edge-replicating horizontal padder; produces repeat_edge_1_stencil_update_stream for the line buffer.
//  Takes an unpadded raster stream of IMG_W x IMG_H pixels.
//  Emits each row as PAD_L copies of pixel 0, then the IMG_W pixels, then PAD_R copies of the last pixel.
//  Feeds the 1x2 line buffer without boundary loss. Valid/ready on both sides; one beat per cycle sustained.
// PARAMETERS
//  DW      16  pixel width in bits (datapath is 16b end to end)
//  IMG_W   64  input pixels per row, >=1
//  IMG_H   64  rows per frame, >=1
//  PAD_L   1   replicated pixels before column 0, >=0
//  PAD_R   1   replicated pixels after column IMG_W-1, >=0
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_data    in   DW  input pixel
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block accepts in_data this cycle
//  out_data   out  DW  padded pixel (repeat_edge stream)
//  out_valid  out  1   out_data valid
//  out_ready  in   1   downstream accepts out_data
//  out_sof    out  1   qualifies first beat of frame (row 0, col 0)
//  out_eol    out  1   qualifies last beat of each padded row
//  frame_done out  1   one-cycle pulse on acceptance of the frame's final beat
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_sof=0, out_eol=0, frame_done=0.
//  Reset also clears ocol=0, orow=0 and hold=0; in_ready=0 while rst_n=0.
//  Reset mid-frame discards the partial frame; the next accepted pixel is treated as row 0, col 0.
//  OUT_W = PAD_L+IMG_W+PAD_R. Beat index ocol in 0..OUT_W-1.
//  Beat source:
//    - ocol==0, or PAD_L+1 <= ocol <= PAD_L+IMG_W-1: consumes a new input pixel.
//    - all other beats replay hold.
//  hold <= in_data on every consumed pixel.
//  Handshake:
//    - adv = !out_valid || out_ready.
//    - in_ready = adv && need_new; combinational from out_ready.
//    - Beat is issued when adv && (!need_new || in_valid).
//    - On issue: out_* registered next edge; latency 1 cycle in->out.
//  Stall: out_valid && !out_ready holds out_data, out_sof and out_eol stable and advances no counter.
//  Bubble: need_new && !in_valid while adv: out_valid drops to 0, counters unchanged.
//  Wrap: issue at ocol==OUT_W-1 sets out_eol, ocol->0, orow++.
//  At orow==IMG_H-1 orow wraps to 0; frame_done pulses when that final beat is accepted (out_valid && out_ready).
//  PAD_L=0/PAD_R=0 degenerate correctly (no replay beats on that side).
//  IMG_W=1: pixel 0 is both left and right source.
//  No arithmetic on data; counters sized $clog2(OUT_W) and $clog2(IMG_H), no overflow past wrap.
// STRUCTURE
//  hls_stream_pkg:
//    - DW default and the pixel_t typedef.
//    - Shared valid/ready beat struct {data, sof, eol}, reused by line buffers and kernels.
//  Sub-module pad_beat_counter: col/row counter with enable, OUT_W and IMG_H wrap, last_col/last_frame flags.
//  Top holds hold reg, need_new decode and output register.
// TESTING
//  IMG_W=4 IMG_H=2 PAD_L=1 PAD_R=1, continuous valid/ready, in 10,20,30,40,50,60,70,80:
//    - out 10,10,20,30,40,40,50,50,60,70,80,80.
//    - out_eol on beats 6 and 12; out_sof on beat 1; frame_done after beat 12.
//  Same frame, out_ready low 3 cycles at beat 2: out_data stays 10, in_ready=0, no data lost or duplicated.
//  in_valid gaps before pixels 20 and 50: out_valid bubbles, output sequence identical to the continuous case.
//  PAD_L=0 PAD_R=2, IMG_W=3, in 1,2,3: out 1,2,3,3,3 with eol on 5th beat.
//  rst_n low after beat 3, then new frame 7,8,9,5: outputs all 0 in reset; then 7,7,8,9,5,5 with sof on the first 7.
//  Two back-to-back frames: second frame's sof on the cycle after first frame_done; no idle cycle inserted.

Source files
------------

// File: rtl/hls_stream_pkg.sv
// Shared stream types and helpers for the HLS-style pixel pipeline.
// The beat struct is reused by the line buffers and kernels downstream.
package hls_stream_pkg;

  localparam int unsigned DW = 16;

  typedef logic [DW-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } beat_t;

  // Counter width that stays at least one bit for single-value ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_beat_counter.sv
// Column/row beat counter for the padded output raster.
// Advances on en; column wraps at OUT_W, row wraps at IMG_H.
module pad_beat_counter
  import hls_stream_pkg::*;
#(
  parameter int unsigned OUT_W = 66,
  parameter int unsigned IMG_H = 64,
  localparam int unsigned CW   = cnt_w(OUT_W),
  localparam int unsigned RW   = cnt_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_frame
);

  localparam logic [CW-1:0] ColMax = CW'(OUT_W - 1);
  localparam logic [RW-1:0] RowMax = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_row;

  assign last_col   = (col_q == ColMax);
  assign last_row   = (row_q == RowMax);
  assign last_frame = last_col && last_row;
  assign col        = col_q;
  assign row        = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/repeat_edge_pad_stream.sv
// Edge-replicating horizontal padder: each row is emitted as PAD_L copies of pixel 0,
// the IMG_W pixels, then PAD_R copies of the last pixel. Valid/ready, one beat per cycle.
module repeat_edge_pad_stream
  import hls_stream_pkg::*;
#(
  parameter int unsigned DW    = hls_stream_pkg::DW,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PAD_L = 1,
  parameter int unsigned PAD_R = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_done
);

  localparam int unsigned OUT_W = PAD_L + IMG_W + PAD_R;
  localparam int unsigned CW    = cnt_w(OUT_W);
  localparam int unsigned RW    = cnt_w(IMG_H);

  // Columns that pull a fresh pixel besides column 0; empty range when IMG_W == 1.
  localparam logic [31:0] NewLo = 32'(PAD_L + 1);
  localparam logic [31:0] NewHi = 32'(PAD_L + IMG_W - 1);

  logic [CW-1:0] ocol;
  logic [RW-1:0] orow;
  logic [31:0]   ocol_ext;
  logic          last_col;
  logic          last_frame;
  logic          first_beat;
  logic          need_new;
  logic          adv;
  logic          issue;

  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          last_q, last_d;

  pad_beat_counter #(
    .OUT_W (OUT_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (issue),
    .col        (ocol),
    .row        (orow),
    .last_col   (last_col),
    .last_frame (last_frame)
  );

  always_comb begin
    ocol_ext   = 32'(ocol);
    need_new   = (ocol == '0) || ((ocol_ext >= NewLo) && (ocol_ext <= NewHi));
    first_beat = (ocol == '0) && (orow == '0);
    adv        = !valid_q || out_ready;
    issue      = adv && (!need_new || in_valid);
  end

  // Gated with rst_n so the source sees no acceptance while the block is held in reset.
  assign in_ready = rst_n && adv && need_new;

  always_comb begin
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    last_d  = last_q;
    if (issue) begin
      valid_d = 1'b1;
      data_d  = need_new ? in_data : hold_q;
      sof_d   = first_beat;
      eol_d   = last_col;
      last_d  = last_frame;
      if (need_new) begin
        hold_d = in_data;
      end
    end else if (adv) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      last_q  <= last_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sof    = sof_q;
  assign out_eol    = eol_q;
  assign frame_done = valid_q && out_ready && last_q;

endmodule

// File: tb/tb_repeat_edge_pad_stream.sv
// Self-checking bench: directed frames with literal expectations plus a randomized run
// compared against a raster-arithmetic model of the padded stream.
module tb_repeat_edge_pad_stream;

  localparam int AW = 4;
  localparam int AH = 2;
  localparam int AL = 1;
  localparam int AR = 1;
  localparam int OW = AL + AW + AR;
  localparam int FB = OW * AH;
  localparam int FP = AW * AH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [15:0] a_in_data, a_out_data;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sof, a_eol, a_fd;
  logic [15:0] b_in_data, b_out_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sof, b_eol, b_fd;

  repeat_edge_pad_stream #(
    .DW(16), .IMG_W(AW), .IMG_H(AH), .PAD_L(AL), .PAD_R(AR)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sof(a_sof), .out_eol(a_eol), .frame_done(a_fd)
  );

  repeat_edge_pad_stream #(
    .DW(16), .IMG_W(3), .IMG_H(1), .PAD_L(0), .PAD_R(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sof(b_sof), .out_eol(b_eol), .frame_done(b_fd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_eq(input string name, input longint act, input longint exp);
    check(act == exp, name, act, exp);
  endtask

  // Model: beat n of the padded stream draws from accepted input pixel src_idx(n).
  function automatic int src_idx(input int n);
    int f, b, r, c, j;
    f = n / FB;
    b = n % FB;
    r = b / OW;
    c = b % OW;
    if (c <= AL) j = 0;
    else if (c < AL + AW) j = c - AL;
    else j = AW - 1;
    return f * FP + r * AW + j;
  endfunction

  function automatic bit is_new(input int n);
    return (n % OW == 0) || (src_idx(n) != src_idx(n - 1));
  endfunction

  typedef struct {
    logic [15:0] data;
    int          gap;
  } px_t;

  typedef struct {
    logic [15:0] data;
    bit          sof;
    bit          eol;
    bit          fd;
  } cap_t;

  px_t         pix_q[$];
  cap_t        cap[$];
  logic [15:0] acc[$];
  logic [15:0] e1[12] = '{10, 10, 20, 30, 40, 40, 50, 50, 60, 70, 80, 80};
  logic [15:0] e4[6] = '{7, 7, 8, 9, 5, 5};

  int n_out = 0;
  bit a_acc = 0;
  bit head_loaded = 0;
  int gap_left = 0;
  int gap_pct = 0;
  int stall_pct = 0;
  int stall_beat = -1;
  int stall_left = 0;
  bit stall_chk = 0;
  int stall_seen = 0;
  int bubble_cnt = 0;
  bit bb_chk = 0;
  bit bb_pending = 0;
  bit bb_done = 0;

  // Source/sink driver for dut_a; inputs change 1 time unit after the rising edge.
  initial begin
    a_in_valid = 0;
    a_in_data = 0;
    a_out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (a_acc) begin
        void'(pix_q.pop_front());
        head_loaded = 0;
        a_in_valid = 0;
      end
      if (!rst_n) begin
        a_in_valid = 0;
      end else if (!a_in_valid && pix_q.size() > 0) begin
        if (!head_loaded) begin
          gap_left = pix_q[0].gap;
          head_loaded = 1;
        end
        if (gap_left > 0) gap_left--;
        else if (int'($urandom_range(99)) >= gap_pct) begin
          a_in_valid = 1;
          a_in_data = pix_q[0].data;
        end
      end
      if (stall_left > 0 && n_out == stall_beat) begin
        a_out_ready = 0;
        stall_left--;
      end else begin
        a_out_ready = int'($urandom_range(99)) >= stall_pct;
      end
    end
  end

  // Compare process for dut_a, sampled on the falling edge.
  logic [15:0] prev_data;
  bit prev_sof, prev_eol, prev_stall, prev_adv, prev_iss;

  always @(negedge clk) begin
    bit adv_e, new_e, iss_e;
    int nb, b, idx;
    if (!rst_n) begin
      check_eq("rst_out_valid", a_out_valid, 0);
      check_eq("rst_out_data", a_out_data, 0);
      check_eq("rst_out_sof", a_sof, 0);
      check_eq("rst_out_eol", a_eol, 0);
      check_eq("rst_frame_done", a_fd, 0);
      check_eq("rst_in_ready", a_in_ready, 0);
      acc.delete();
      n_out = 0;
      a_acc = 0;
      prev_adv = 0;
      prev_stall = 0;
      bb_pending = 0;
    end else begin
      a_acc = a_in_valid && a_in_ready;
      if (prev_adv) check_eq("out_valid_after_issue", a_out_valid, prev_iss);
      if (prev_stall) begin
        check_eq("stall_valid_held", a_out_valid, 1);
        check_eq("stall_data_held", a_out_data, prev_data);
        check_eq("stall_sof_held", a_sof, prev_sof);
        check_eq("stall_eol_held", a_eol, prev_eol);
      end
      if (bb_pending) begin
        check_eq("b2b_sof_next_cycle", a_out_valid && a_sof, 1);
        bb_pending = 0;
        bb_done = 1;
      end
      if (!a_out_valid) bubble_cnt++;
      nb = n_out + (a_out_valid ? 1 : 0);
      new_e = is_new(nb);
      adv_e = !a_out_valid || a_out_ready;
      iss_e = adv_e && (!new_e || a_in_valid);
      check_eq("in_ready", a_in_ready, adv_e && new_e);
      if (a_out_valid && a_out_ready) begin
        b = n_out % FB;
        idx = src_idx(n_out);
        if (idx >= acc.size()) check(0, "beat_has_source", idx, acc.size());
        else check_eq("out_data", a_out_data, acc[idx]);
        check_eq("out_sof", a_sof, b == 0);
        check_eq("out_eol", a_eol, (b % OW) == OW - 1);
        check_eq("frame_done", a_fd, b == FB - 1);
        cap.push_back('{a_out_data, a_sof, a_eol, a_fd});
        if (bb_chk && a_fd) begin
          bb_pending = 1;
          bb_chk = 0;
        end
        n_out++;
      end else begin
        check_eq("frame_done_idle", a_fd, 0);
      end
      if (stall_chk && a_out_valid && !a_out_ready) begin
        stall_seen++;
        check_eq("stall_out_data", a_out_data, 10);
        check_eq("stall_in_ready", a_in_ready, 0);
      end
      if (a_in_valid && a_in_ready) acc.push_back(a_in_data);
      prev_adv = adv_e;
      prev_iss = iss_e;
      prev_stall = a_out_valid && !a_out_ready;
      prev_data = a_out_data;
      prev_sof = a_sof;
      prev_eol = a_eol;
    end
  end

  task automatic push_px(input logic [15:0] d, input int gap);
    pix_q.push_back('{d, gap});
  endtask

  task automatic wait_beats(input int target, input int limit);
    int c = 0;
    while (n_out < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check(n_out >= target, "beats_within_budget", n_out, target);
  endtask

  task automatic check_frame1(input string tag);
    check_eq({tag, "_beat_count"}, cap.size(), 12);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      check_eq({tag, "_data"}, cap[i].data, e1[i]);
      check_eq({tag, "_sof"}, cap[i].sof, i == 0);
      check_eq({tag, "_eol"}, cap[i].eol, (i == 5) || (i == 11));
      check_eq({tag, "_done"}, cap[i].fd, i == 11);
    end
  endtask

  initial begin
    int bexp[5] = '{1, 2, 3, 3, 3};
    logic [15:0] bvals[3] = '{1, 2, 3};
    int b_idx, b_out, base, bub0;

    b_in_valid = 0;
    b_in_data = 0;
    b_out_ready = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // dut_b: PAD_L=0, PAD_R=2, IMG_W=3, one row.
    @(posedge clk);
    #1;
    b_idx = 0;
    b_out = 0;
    b_in_valid = 1;
    b_in_data = bvals[0];
    for (int c = 0; c < 30 && b_out < 5; c++) begin
      @(negedge clk);
      if (b_out_valid) begin
        check_eq("b_data", b_out_data, bexp[b_out]);
        check_eq("b_sof", b_sof, b_out == 0);
        check_eq("b_eol", b_eol, b_out == 4);
        check_eq("b_done", b_fd, b_out == 4);
        b_out++;
      end
      if (b_in_valid && b_in_ready) b_idx++;
      @(posedge clk);
      #1;
      b_in_valid = b_idx < 3;
      b_in_data = bvals[(b_idx < 3) ? b_idx : 2];
    end
    check_eq("b_beats", b_out, 5);

    // Continuous frame.
    cap.delete();
    for (int i = 0; i < 8; i++) push_px(16'((i + 1) * 10), 0);
    wait_beats(n_out + 12, 300);
    check_frame1("cont");

    // Downstream stall of 3 cycles on the second beat.
    cap.delete();
    stall_seen = 0;
    stall_beat = n_out + 1;
    stall_left = 3;
    stall_chk = 1;
    for (int i = 0; i < 8; i++) push_px(16'((i + 1) * 10), 0);
    wait_beats(n_out + 12, 300);
    stall_chk = 0;
    check_eq("stall_cycles", stall_seen, 3);
    check_frame1("stall");

    // Input gaps before pixels 20 and 50.
    cap.delete();
    bub0 = bubble_cnt;
    for (int i = 0; i < 8; i++) push_px(16'((i + 1) * 10), (i == 1 || i == 4) ? 2 : 0);
    wait_beats(n_out + 12, 300);
    check(bubble_cnt - bub0 >= 4, "gap_bubbles", bubble_cnt - bub0, 4);
    check_frame1("gaps");

    // Reset mid-frame, then a fresh frame.
    base = n_out;
    for (int i = 0; i < 8; i++) push_px(16'(i + 1), 0);
    for (int c = 0; c < 100 && n_out < base + 3; c++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    pix_q.delete();
    head_loaded = 0;
    cap.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    push_px(7, 0); push_px(8, 0); push_px(9, 0); push_px(5, 0);
    for (int i = 1; i <= 4; i++) push_px(16'(i), 0);
    wait_beats(12, 300);
    check_eq("rst_frame_count", cap.size(), 12);
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      check_eq("rst_frame_data", cap[i].data, e4[i]);
      check_eq("rst_frame_sof", cap[i].sof, i == 0);
    end

    // Back-to-back frames.
    bb_done = 0;
    bb_chk = 1;
    for (int i = 0; i < 2 * FP; i++) push_px(16'($urandom), 0);
    wait_beats(n_out + 2 * FB, 400);
    check_eq("b2b_checked", bb_done, 1);
    bb_chk = 0;

    // Randomized traffic on both sides.
    gap_pct = 30;
    stall_pct = 30;
    for (int i = 0; i < 6 * FP; i++) push_px(16'($urandom), int'($urandom_range(3)) == 0 ? 1 : 0);
    wait_beats(n_out + 6 * FB, 3000);
    gap_pct = 0;
    stall_pct = 0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
